mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
//  Shares the single SystemBus memory port between the instruction fetch path
//  (icache, port 0) and the data memory path (dcache, port 1).
//  Latches the winning request and drives it downstream until the memory acknowledges.
//  Returns the response to the granted requester and aborts stalled transfers via a watchdog.
//  Sits between the icache/dcache refill/access logic and the SystemBus.
// PARAMETERS
//  FAIR            1    1: round-robin between ports; 0: fixed priority, port 1 (data) wins
//  TIMEOUT_CYCLES  255  max cycles mem_valid may wait for mem_ready; 0 disables the watchdog
// PORTS
//  clk         in   1   clock; all state updates on posedge
//  rst         in   1   synchronous, active-high reset
//  m_valid     in   2   per-port request valid; held until that port's m_ready
//  m_addr      in   2x32 per-port byte address
//  m_wdata     in   2x32 per-port write data
//  m_wstrb     in   2x4  per-port byte strobes (writes only)
//  m_write     in   2   per-port 1=write, 0=read
//  m_ready     out  2   per-port completion pulse, 1 cycle
//  m_rdata     out  32  read data, valid with m_ready (shared by both ports)
//  m_error     out  2   per-port error, valid with m_ready
//  mem_valid   out  1   downstream request valid
//  mem_addr    out  32  latched address
//  mem_wdata   out  32  latched write data
//  mem_wstrb   out  4   latched strobes
//  mem_write   out  1   latched direction
//  mem_ready   in   1   downstream completion
//  mem_rdata   in   32  downstream read data
//  mem_error   in   1   downstream bus error, qualified by mem_ready
//  grant       out  2   one-hot owner of the bus, 0 when idle
//  busy        out  1   state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE, last=port0, wdog=0.
//    All mem_* outputs, m_ready, m_error, grant and busy are 0.
//  - FSM states: IDLE, OWN0, OWN1.
//  - IDLE, no m_valid: stay in IDLE.
//  - IDLE, single m_valid[i]: latch port i's addr/wdata/wstrb/write and go to OWN_i.
//  - IDLE, both valid: FAIR=1 picks the port != last; FAIR=0 picks port 1.
//  - OWN_i outputs: mem_valid=1, mem_* = latched fields, grant[i]=1.
//  - Latched fields are stable for the whole ownership. Requester changes after the latch are ignored.
//  - OWN_i, mem_ready=1 (same cycle, combinational):
//      m_ready[i]=1, m_rdata=mem_rdata, m_error[i]=mem_error.
//      Next cycle: state=IDLE, last=i.
//  - Min latency: m_valid sampled in IDLE at cycle N; mem_valid at N+1.
//    If mem_ready arrives at N+1, m_ready is also at N+1. IDLE again at N+2.
//  - Requester must drop m_valid, or present a new request, at N+2. m_valid in IDLE is always a new request.
//  - No back-to-back grant without an IDLE cycle. Guaranteed 1 idle cycle between transfers.
//  - Watchdog: wdog counts cycles in OWN_i with mem_ready=0 and clears on entry to OWN_i.
//    Width is $clog2(TIMEOUT_CYCLES+1).
//    When wdog==TIMEOUT_CYCLES-1 with mem_ready=0 (mem_ready has been low for TIMEOUT_CYCLES cycles):
//    m_ready[i]=1, m_error[i]=1, m_rdata=0. Next cycle: IDLE, last=i.
//  - mem_ready on the same cycle as the watchdog expiry wins as a normal completion.
//  - mem_ready/mem_error while IDLE are ignored: no m_ready, no state change.
//  - m_ready/m_error for the ungranted port are always 0. m_rdata=0 when no completion.
//  - rst mid-transfer: IDLE and all outputs 0 at the next edge. No m_ready is produced for the aborted request.
// TESTING
//  1. Read on port0 only, addr=0x80000000; mem_ready after 3 cycles with rdata=0x00000013
//     -> mem_valid high 3 cycles, m_ready[0] pulse, m_rdata=0x13.
//  2. Both ports valid in the same cycle, FAIR=1, last=0
//     -> port1 served first, then port0 after 1 IDLE cycle; grant 2'b10 then 2'b01.
//  3. FAIR=0, port1 re-requests continuously with port0 also valid
//     -> port1 granted every transfer; port0 starves; grant never 2'b01.
//  4. Port1 write addr=0x80001000, wdata=0xDEADBEEF, wstrb=4'b0011; port1 changes m_addr mid-transfer
//     -> mem_addr stays 0x80001000 and mem_wstrb stays 0011 until mem_ready.
//  5. TIMEOUT_CYCLES=4, mem_ready never asserted
//     -> m_ready[i]=m_error[i]=1 on the 4th OWN cycle; IDLE next; a late mem_ready is ignored.
//  6. rst asserted 2 cycles into OWN0
//     -> mem_valid, grant, busy = 0 at the next edge; no m_ready; port1 granted normally afterwards.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port arbiter for the shared SystemBus memory port.
// Port 0 is the instruction fetch path and port 1 is the data path.
// The winning request is latched and held on the bus until the memory completes it.
// A watchdog aborts a transfer that memory never completes.
module mem_arbiter #(
  parameter bit          FAIR           = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [1:0]       i_m_valid,
  input  logic [1:0][31:0] i_m_addr,
  input  logic [1:0][31:0] i_m_wdata,
  input  logic [1:0][3:0]  i_m_wstrb,
  input  logic [1:0]       i_m_write,
  output logic [1:0]       o_m_ready,
  output logic [31:0]      o_m_rdata,
  output logic [1:0]       o_m_error,
  output logic             o_mem_valid,
  output logic [31:0]      o_mem_addr,
  output logic [31:0]      o_mem_wdata,
  output logic [3:0]       o_mem_wstrb,
  output logic             o_mem_write,
  input  logic             i_mem_ready,
  input  logic [31:0]      i_mem_rdata,
  input  logic             i_mem_error,
  output logic [1:0]       o_grant,
  output logic             o_busy
);

  // Keep at least one bit so a disabled watchdog still elaborates cleanly.
  localparam int unsigned WdogW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [WdogW-1:0] WdogMax =
      (TIMEOUT_CYCLES == 0) ? '0 : WdogW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

  state_e            r_state, w_state_next;
  logic              r_last, w_last_next;
  logic [WdogW-1:0]  r_wdog, w_wdog_next;
  logic [31:0]       r_addr, r_wdata;
  logic [3:0]        r_wstrb;
  logic              r_write;
  logic              w_latch;
  logic              w_pick;
  logic              w_port;
  logic              w_expire;

  // Arbitration, ownership outputs, completion/abort routing and next state.
  always_comb begin
    w_state_next = r_state;
    w_last_next  = r_last;
    w_wdog_next  = r_wdog;
    w_latch      = 1'b0;
    w_pick       = 1'b0;
    w_port       = 1'b0;
    w_expire     = (TIMEOUT_CYCLES != 0) && (r_wdog == WdogMax);
    o_m_ready    = 2'b00;
    o_m_rdata    = '0;
    o_m_error    = 2'b00;
    o_mem_valid  = 1'b0;
    o_mem_addr   = '0;
    o_mem_wdata  = '0;
    o_mem_wstrb  = '0;
    o_mem_write  = 1'b0;
    o_grant      = 2'b00;
    o_busy       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (|i_m_valid) begin
          w_latch = 1'b1;
          // Contention: round-robin away from the last owner, or data port wins.
          if (i_m_valid == 2'b11) w_pick = FAIR ? ~r_last : 1'b1;
          else                    w_pick = i_m_valid[1];
          w_state_next = w_pick ? StOwn1 : StOwn0;
          w_wdog_next  = '0;
        end
      end
      StOwn0, StOwn1: begin
        w_port          = (r_state == StOwn1);
        o_mem_valid     = 1'b1;
        o_mem_addr      = r_addr;
        o_mem_wdata     = r_wdata;
        o_mem_wstrb     = r_wstrb;
        o_mem_write     = r_write;
        o_grant[w_port] = 1'b1;
        o_busy          = 1'b1;
        if (i_mem_ready) begin
          // A real completion beats a simultaneous watchdog expiry.
          o_m_ready[w_port] = 1'b1;
          o_m_rdata         = i_mem_rdata;
          o_m_error[w_port] = i_mem_error;
          w_state_next      = StIdle;
          w_last_next       = w_port;
        end else if (w_expire) begin
          o_m_ready[w_port] = 1'b1;
          o_m_error[w_port] = 1'b1;
          w_state_next      = StIdle;
          w_last_next       = w_port;
        end else begin
          w_wdog_next = r_wdog + WdogW'(1);
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // State, last-owner, watchdog and latched request registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_last  <= 1'b0;
      r_wdog  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_write <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_last  <= w_last_next;
      r_wdog  <= w_wdog_next;
      if (w_latch) begin
        r_addr  <= i_m_addr[w_pick];
        r_wdata <= i_m_wdata[w_pick];
        r_wstrb <= i_m_wstrb[w_pick];
        r_write <= i_m_write[w_pick];
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one round-robin instance with a 4-cycle watchdog and one
// fixed-priority instance with the watchdog disabled, both fed the same stimulus.
module tb_mem_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       m_valid;
  logic [1:0][31:0] m_addr, m_wdata;
  logic [1:0][3:0]  m_wstrb;
  logic [1:0]       m_write;
  logic             mem_ready;
  logic [31:0]      mem_rdata;
  logic             mem_error;

  logic [1:0][1:0]  mready, merror, grant;
  logic [1:0][31:0] rdata, maddr, mwdata;
  logic [1:0][3:0]  mwstrb;
  logic [1:0]       mvalid, mwrite, busy;

  always #5 clk = ~clk;

  mem_arbiter #(.FAIR(1'b1), .TIMEOUT_CYCLES(4)) u_dut0 (
    .i_clk(clk), .i_rst(rst), .i_m_valid(m_valid), .i_m_addr(m_addr), .i_m_wdata(m_wdata),
    .i_m_wstrb(m_wstrb), .i_m_write(m_write), .o_m_ready(mready[0]), .o_m_rdata(rdata[0]),
    .o_m_error(merror[0]), .o_mem_valid(mvalid[0]), .o_mem_addr(maddr[0]),
    .o_mem_wdata(mwdata[0]), .o_mem_wstrb(mwstrb[0]), .o_mem_write(mwrite[0]),
    .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata), .i_mem_error(mem_error),
    .o_grant(grant[0]), .o_busy(busy[0])
  );

  mem_arbiter #(.FAIR(1'b0), .TIMEOUT_CYCLES(0)) u_dut1 (
    .i_clk(clk), .i_rst(rst), .i_m_valid(m_valid), .i_m_addr(m_addr), .i_m_wdata(m_wdata),
    .i_m_wstrb(m_wstrb), .i_m_write(m_write), .o_m_ready(mready[1]), .o_m_rdata(rdata[1]),
    .o_m_error(merror[1]), .o_mem_valid(mvalid[1]), .o_mem_addr(maddr[1]),
    .o_mem_wdata(mwdata[1]), .o_mem_wstrb(mwstrb[1]), .o_mem_write(mwrite[1]),
    .i_mem_ready(mem_ready), .i_mem_rdata(mem_rdata), .i_mem_error(mem_error),
    .o_grant(grant[1]), .o_busy(busy[1])
  );

  typedef struct packed {
    logic [1:0]  ready;
    logic [31:0] rdata;
    logic [1:0]  err;
    logic        mv;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wr;
    logic [1:0]  grant;
    logic        busy;
  } outs_t;

  typedef struct {
    logic [1:0]  v;
    logic        rdy;
    logic [31:0] rd;
    logic        err;
    logic [1:0]  g;
    logic [1:0]  mr;
    logic [31:0] erd;
    logic [31:0] ea;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: owner index (-1 = idle), cycles spent owning, last owner.
  int          own [2];
  int          age [2];
  int          last[2];
  int          fair[2] = '{1, 0};
  int          tmo [2] = '{4, 0};
  logic [31:0] l_addr [2];
  logic [31:0] l_wdata[2];
  logic [3:0]  l_wstrb[2];
  logic        l_wr   [2];

  function automatic outs_t got(int d);
    outs_t o;
    o = '{ready: mready[d], rdata: rdata[d], err: merror[d], mv: mvalid[d], addr: maddr[d],
          wdata: mwdata[d], wstrb: mwstrb[d], wr: mwrite[d], grant: grant[d], busy: busy[d]};
    return o;
  endfunction

  function automatic bit times_out(int d);
    return (tmo[d] != 0) && (age[d] + 1 == tmo[d]);
  endfunction

  function automatic outs_t model_out(int d);
    outs_t e;
    e = '0;
    if (own[d] >= 0) begin
      e.mv = 1'b1; e.addr = l_addr[d]; e.wdata = l_wdata[d];
      e.wstrb = l_wstrb[d]; e.wr = l_wr[d]; e.busy = 1'b1;
      e.grant[own[d]] = 1'b1;
      if (mem_ready) begin
        e.ready[own[d]] = 1'b1; e.rdata = mem_rdata; e.err[own[d]] = mem_error;
      end else if (times_out(d)) begin
        e.ready[own[d]] = 1'b1; e.err[own[d]] = 1'b1;
      end
    end
    return e;
  endfunction

  task automatic model_update(int d);
    int p;
    if (rst) begin
      own[d] = -1; last[d] = 0; age[d] = 0;
    end else if (own[d] < 0) begin
      if (m_valid != 2'b00) begin
        if (m_valid == 2'b11) p = (fair[d] != 0) ? 1 - last[d] : 1;
        else                  p = m_valid[1] ? 1 : 0;
        own[d] = p; age[d] = 0;
        l_addr[d] = m_addr[p]; l_wdata[d] = m_wdata[p];
        l_wstrb[d] = m_wstrb[p]; l_wr[d] = m_write[p];
      end
    end else if (mem_ready || times_out(d)) begin
      last[d] = own[d]; own[d] = -1;
    end else begin
      age[d] = age[d] + 1;
    end
  endtask

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): got %h want %h", name, cyc, act, exp);
    end
  endtask

  // Sample away from the rising edge and compare both instances against the model.
  task automatic settle();
    outs_t e, a;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      e = model_out(d);
      a = got(d);
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL model dut%0d (cycle %0d): got %h want %h", d, cyc, a, e);
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    model_update(0);
    model_update(1);
    cyc++;
    #1;
  endtask

  task automatic drive(logic [1:0] v, logic rdy, logic [31:0] rd, logic err);
    m_valid = v; mem_ready = rdy; mem_rdata = rd; mem_error = err;
  endtask

  vec_t tbl[10];
  int   n_g1;

  initial begin
    own = '{-1, -1}; age = '{0, 0}; last = '{0, 0};
    rst = 1'b1;
    m_addr  = '{32'h8000_1000, 32'h8000_0000};
    m_wdata = '0; m_wstrb = '0; m_write = '0;
    drive(2'b00, 1'b0, 32'h0, 1'b0);
    advance();
    advance();
    rst = 1'b0;

    // Reset state.
    settle();
    chk("reset dut0 outputs", 32'(got(0)), 32'h0);
    chk("reset dut0 busy", 32'(busy[0]), 32'h0);
    chk("reset dut1 grant", 32'(grant[1]), 32'h0);
    advance();

    // Single read on port 0, then contention with round-robin (checked on dut0).
    //            v      rdy   rd            err   g      mr     erd           ea
    tbl[0] = '{2'b01, 1'b0, 32'h0,        1'b0, 2'b00, 2'b00, 32'h0,        32'h0};
    tbl[1] = '{2'b01, 1'b0, 32'h0,        1'b0, 2'b01, 2'b00, 32'h0,        32'h8000_0000};
    tbl[2] = '{2'b01, 1'b0, 32'h0,        1'b0, 2'b01, 2'b00, 32'h0,        32'h8000_0000};
    tbl[3] = '{2'b01, 1'b1, 32'h13,       1'b0, 2'b01, 2'b01, 32'h13,       32'h8000_0000};
    tbl[4] = '{2'b00, 1'b0, 32'h0,        1'b0, 2'b00, 2'b00, 32'h0,        32'h0};
    tbl[5] = '{2'b11, 1'b0, 32'h0,        1'b0, 2'b00, 2'b00, 32'h0,        32'h0};
    tbl[6] = '{2'b11, 1'b1, 32'hA5,       1'b0, 2'b10, 2'b10, 32'hA5,       32'h8000_1000};
    tbl[7] = '{2'b11, 1'b0, 32'h0,        1'b0, 2'b00, 2'b00, 32'h0,        32'h0};
    tbl[8] = '{2'b11, 1'b1, 32'h5A,       1'b0, 2'b01, 2'b01, 32'h5A,       32'h8000_0000};
    tbl[9] = '{2'b00, 1'b1, 32'h77,       1'b1, 2'b00, 2'b00, 32'h0,        32'h0};
    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].v, tbl[i].rdy, tbl[i].rd, tbl[i].err);
      settle();
      chk($sformatf("vec%0d grant", i), 32'(grant[0]), 32'(tbl[i].g));
      chk($sformatf("vec%0d m_ready", i), 32'(mready[0]), 32'(tbl[i].mr));
      chk($sformatf("vec%0d m_rdata", i), rdata[0], tbl[i].erd);
      chk($sformatf("vec%0d mem_valid", i), 32'(mvalid[0]), 32'(tbl[i].g != 2'b00));
      chk($sformatf("vec%0d mem_addr", i), maddr[0], tbl[i].ea);
      advance();
    end

    // Fixed priority: data port takes every transfer while both request.
    n_g1 = 0;
    for (int i = 0; i < 8; i++) begin
      drive(2'b11, 1'b1, 32'h1000 + 32'(i), 1'b0);
      settle();
      chk("fixed-prio port0 never granted", 32'(grant[1] == 2'b01), 32'h0);
      if (grant[1] == 2'b10) n_g1++;
      advance();
    end
    chk("fixed-prio port1 grant count", 32'(n_g1), 32'd4);

    // Port 1 write; requester changes its fields after the latch.
    m_addr[1] = 32'h8000_1000; m_wdata[1] = 32'hDEAD_BEEF; m_wstrb[1] = 4'b0011;
    m_write[1] = 1'b1;
    for (int c = 0; c < 5; c++) begin
      drive((c < 4) ? 2'b10 : 2'b00, c == 3, 32'h0, 1'b0);
      settle();
      if (c >= 1 && c <= 3) begin
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("hold dut%0d mem_addr", d), maddr[d], 32'h8000_1000);
          chk($sformatf("hold dut%0d mem_wstrb", d), 32'(mwstrb[d]), 32'h3);
          chk($sformatf("hold dut%0d mem_wdata", d), mwdata[d], 32'hDEAD_BEEF);
          chk($sformatf("hold dut%0d mem_write", d), 32'(mwrite[d]), 32'h1);
        end
      end
      advance();
      m_addr[1] = 32'h1234_5678; m_wstrb[1] = 4'b1111; m_wdata[1] = 32'h0;
    end
    m_write[1] = 1'b0;

    // Watchdog on dut0 (4 cycles); dut1 has it disabled and keeps waiting.
    for (int c = 0; c < 7; c++) begin
      drive((c < 5) ? 2'b01 : 2'b00, c == 5, 32'hFFFF_FFFF, 1'b0);
      settle();
      if (c >= 1 && c <= 3) chk("wdog early no ready", 32'(mready[0]), 32'h0);
      if (c == 4) begin
        chk("wdog expiry ready", 32'(mready[0]), 32'h1);
        chk("wdog expiry error", 32'(merror[0]), 32'h1);
        chk("wdog expiry rdata", rdata[0], 32'h0);
        chk("wdog disabled no ready", 32'(mready[1]), 32'h0);
      end
      if (c == 5) begin
        chk("late mem_ready ignored", 32'(mready[0]), 32'h0);
        chk("idle after expiry", 32'(busy[0]), 32'h0);
      end
      advance();
    end

    // Reset two cycles into an OWN0 transfer, then a normal port 1 grant.
    for (int c = 0; c < 6; c++) begin
      rst = (c == 2);
      drive((c < 3) ? 2'b01 : ((c < 5) ? 2'b10 : 2'b00), c == 4, 32'hCAFE, 1'b0);
      settle();
      if (c == 3) begin
        for (int d = 0; d < 2; d++) begin
          chk($sformatf("rst dut%0d outputs", d), 32'(got(d) != '0), 32'h0);
        end
      end
      if (c == 4) begin
        chk("post-rst grant", 32'(grant[0]), 32'h2);
        chk("post-rst m_ready", 32'(mready[0]), 32'h2);
      end
      advance();
    end
    rst = 1'b0;

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      rst        = ($urandom_range(0, 199) == 0);
      m_valid    = 2'($urandom_range(0, 3));
      m_addr     = {$urandom, $urandom};
      m_wdata    = {$urandom, $urandom};
      m_wstrb    = 8'($urandom);
      m_write    = 2'($urandom_range(0, 3));
      mem_ready  = ($urandom_range(0, 2) == 0);
      mem_rdata  = $urandom;
      mem_error  = 1'($urandom_range(0, 1));
      settle();
      advance();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
